regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the RISC-V core; successor to the fixed 2R/1W 32x32 file.
- Generalised in data width, depth, read-port count and write-port count.
- Adds a per-register busy scoreboard: issue marks a destination busy, writeback clears it; read ports report hazards so decode can stall.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register in bits.
- NREGS, 32, register count; power of two, 4..64; AW = log2(NREGS) is a derived localparam.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 2, number of write ports (1..2); higher index has priority.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rd_busy  out  NUM_RD  port k's register has a pending write.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*XLEN  write data.
- iss_en  in  1  issue strobe; marks iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- busy_cnt  out  AW+1  registered count of busy registers.
- stall  out  1  OR of rd_busy; combinational.

Behaviour:
- Reset is synchronous on the clk edge while rst=0. It forces:
  - all registers to 0;
  - all busy bits to 0;
  - busy_cnt to 0.
  - Writes and issues in that cycle are ignored.
- Reset applied mid-operation discards all pending busy state; no partial updates.
- Register 0:
  - reads always return 0;
  - writes to address 0 are dropped;
  - issue to address 0 never sets busy; rd_busy is 0 for address 0.
- Reads are combinational (zero latency), and rd_data follows rd_addr asynchronously.
- Writes commit at the rising edge when wr_en[j]=1 and wr_addr[j]!=0.
- Two write ports targeting the same address in one cycle: the higher-index port's data is stored.
- Scoreboard, per register r (r!=0), next-state each edge:
  - set = iss_en & (iss_addr==r);
  - clr = any wr_en[j] & (wr_addr[j]==r);
  - busy_next = set | (busy & ~clr). Issue wins over a simultaneous clear, because the new producer is younger.
  - A write to a non-busy register is legal: data is stored and busy stays 0.
  - An issue to an already-busy register keeps it busy (no count).
- busy_cnt is the population count of busy_next, registered. It equals the count of busy bits after the edge, ranges 0..NREGS-1, and cannot overflow.
- rd_busy[k] = busy[rd_addr[k]], using the registered busy (pre-edge) value, with the bypass rule below applied.
- No state machine beyond the busy vector. Array and busy bits are the only storage; busy_cnt is a registered mirror.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - A same-cycle write to the read address is forwarded to rd_data, using the highest-index matching write port.
  - rd_busy for that port is forced to 0 unless iss_en targets the same register in that cycle.
  - Decode sees writeback results without a one-cycle bubble.
- Undefined:
  - rd_data returns the pre-edge stored value.
  - rd_busy reflects the registered busy bit, so a reader of a register being written that cycle stalls one extra cycle.
- The x0 rules hold in both builds.

Decomposition:
- Shared package regfile_pkg:
  - XLEN default;
  - AW/NREGS helper function (clog2);
  - REG_ZERO constant;
  - typedef of the write-port record (en, addr, data) for use by writeback.
- One sub-module: regfile_sb_ctrl, holding the busy vector, set/clear/priority logic and popcount for busy_cnt.
- Storage array, write priority and read muxing stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wr_en=2'b11 to x5 -> every read is 0; rd_busy=0; busy_cnt=0; after release, x5 reads 0.
- x0 protection: write 0xDEADBEEF to x0 and issue x0 -> rd_data=0, rd_busy=0, busy_cnt unchanged.
- Write priority: port0 writes x7=0x11111111 and port1 writes x7=0x22222222 in the same cycle -> next cycle x7 reads 0x22222222.
- Scoreboard lifecycle: issue x3 -> busy_cnt=1 and reading x3 gives rd_busy=1, stall=1; write x3=0x5 next cycle -> busy_cnt=0, read gives 0x5, rd_busy=0.
- Simultaneous set and clear: x9 busy, then issue x9 in the same cycle as a write to x9 -> x9 stays busy, busy_cnt unchanged, data updated.
- Bypass: read x4 while writing x4=0xCAFE0001 in the same cycle -> with REGFILE_BYPASS_EN, rd_data=0xCAFE0001 and rd_busy=0 that cycle; without it, the old value is returned and rd_busy holds its pre-edge value.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: constants, types and helpers shared by the multi-port register
// file, its scoreboard controller and the writeback stage.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ZERO     = 0;
    localparam int AW_MAX       = 6;

    // Number of address bits needed to index nRegs registers (ceil(log2)).
    function automatic int regfileAddrBits(input int nRegs);
        int bits;
        bits = 0;
        while ((1 << bits) < nRegs) begin
            bits++;
        end
        return bits;
    endfunction

    // One writeback port as produced by the writeback stage.
    typedef struct packed {
        logic                    en;
        logic [AW_MAX-1:0]       addr;
        logic [XLEN_DEFAULT-1:0] data;
    } wrPort_t;

endpackage

// File: rtl/regfile_sb_ctrl.sv
// regfile_sb_ctrl: per-register busy scoreboard. Issue marks a destination
// busy, any writeback to it clears it, and an issue in the same cycle as a
// clear wins because it belongs to the younger producer. Also keeps a
// registered population count of the busy bits. Register 0 is never busy.
module regfile_sb_ctrl
    import regfile_pkg::*;
#(
    parameter  int NREGS  = 32,
    parameter  int NUM_WR = 2,
    localparam int AW     = regfileAddrBits(NREGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_WR-1:0]    wr_en_i,
    input  logic [NUM_WR*AW-1:0] wr_addr_i,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_addr_i,
    output logic [NREGS-1:0]     busy_o,
    output logic [AW:0]          busy_cnt_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busyCnt_q;
    logic [AW:0]      busyCnt_d;
    logic             setHit;
    logic             clrHit;

    // Next busy vector from set/clear per register, and its population count.
    always_comb begin
        busy_d    = '0;
        busyCnt_d = '0;
        setHit    = 1'b0;
        clrHit    = 1'b0;
        for (int r = REG_ZERO + 1; r < NREGS; r++) begin
            setHit = iss_en_i && (iss_addr_i == AW'(r));
            clrHit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                clrHit = clrHit || (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == AW'(r)));
            end
            busy_d[r] = setHit || (busy_q[r] && !clrHit);
            busyCnt_d = busyCnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    // Busy vector and count register; reset discards all pending state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q    <= '0;
            busyCnt_q <= '0;
        end else begin
            busy_q    <= busy_d;
            busyCnt_q <= busyCnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = busyCnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised multi-port integer register file with a busy
// scoreboard. Reads are combinational, writes commit on the rising edge with
// the highest-index write port winning, x0 always reads zero.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle writeback data
// to the read ports and hides the busy flag of the register being written.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = 32,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 2,
    localparam int AW     = regfileAddrBits(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    output logic [AW:0]            busy_cnt,
    output logic                   stall
);

    logic [XLEN-1:0]  regFile_q [NREGS];
    logic [NREGS-1:0] busyVec;
    logic [AW-1:0]    rdIdx;

    regfile_sb_ctrl #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR)
    ) u_sbCtrl (
        .clk_i      (clk),
        .rst_ni     (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .busy_o     (busyVec),
        .busy_cnt_o (busy_cnt)
    );

    // Storage array: clear on reset, otherwise commit writes in port order so the higher index wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regFile_q[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO))) begin
                    regFile_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Read muxing per port with optional writeback forwarding; x0 overrides everything.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rdIdx   = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdIdx                     = rd_addr[k*AW +: AW];
            rd_data[k*XLEN +: XLEN]   = regFile_q[rdIdx];
            rd_busy[k]                = busyVec[rdIdx];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (rst && wr_en[j] && (wr_addr[j*AW +: AW] == rdIdx)) begin
                    rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                    rd_busy[k]              = iss_en && (iss_addr == rdIdx);
                end
            end
`endif
            if (rdIdx == AW'(REG_ZERO)) begin
                rd_data[k*XLEN +: XLEN] = '0;
                rd_busy[k]              = 1'b0;
            end
        end
    end

    assign stall = |rd_busy;

endmodule
